encoder_emulator: RTL

//  Quadrature encoder emulator: the transmit-side counterpart of the tachometer.

---
 rtl/encoder_pkg.sv | 35 +++
 rtl/encoder_emulator_step_timer.sv | 28 ++
 rtl/encoder_emulator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
// Phase encoding is chosen so that forward motion is a plain +1 on the phase code.
package encoder_pkg;

   localparam int MIN_PERIOD = 2;

   typedef enum logic {IDLE, RUN} emu_state_t;

   typedef enum logic [1:0] {
      P00 = 2'd0,
      P10 = 2'd1,
      P11 = 2'd2,
      P01 = 2'd3
   } quad_phase_t;

   function automatic quad_phase_t next_phase(input quad_phase_t phase, input logic dir);
      quad_phase_t nxt;
      case (phase)
         P00:     nxt = dir ? P10 : P01;
         P10:     nxt = dir ? P11 : P00;
         P11:     nxt = dir ? P01 : P10;
         default: nxt = dir ? P00 : P11;
      endcase
      return nxt;
   endfunction

   function automatic logic phase_a(input quad_phase_t phase);
      return (phase == P10) || (phase == P11);
   endfunction

   function automatic logic phase_b(input quad_phase_t phase);
      return (phase == P11) || (phase == P01);
   endfunction

endpackage

// File: rtl/encoder_emulator_step_timer.sv
// Loadable down-counter pacing the emulator's quadrature steps.
// Holds at zero; zero is decoded from the count register.
module step_timer #(
   parameter int PERIOD_W = 32
) (
   input  logic                clock,
   input  logic                system_reset,
   input  logic                load,
   input  logic [PERIOD_W-1:0] load_val,
   input  logic                run,
   output logic                zero
);

   logic [PERIOD_W-1:0] count_reg;

   always_ff @(posedge clock or negedge system_reset) begin
      if (!system_reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (run && (count_reg != '0)) begin
         count_reg <= count_reg - PERIOD_W'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: emits A/B levels, a step strobe and a signed position
// at a programmable step period, with a one-deep shadow register for period updates.
module encoder_emulator
   import encoder_pkg::*;
#(
   parameter int PERIOD_W     = 32,
   parameter int POS_W        = 32,
   parameter int MIN_PERIOD   = encoder_pkg::MIN_PERIOD,
   parameter int RESET_PERIOD = 20
) (
   input  logic                clock,
   input  logic                system_reset,
   input  logic                enable,
   input  logic                dir,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                period_valid,
   output logic                period_ready,
   output logic                enc_a,
   output logic                enc_b,
   output logic                encoder_data,
   output logic                step_pulse,
   output logic [POS_W-1:0]    position
);

   emu_state_t          state_reg, state_next;
   quad_phase_t         phase_reg, phase_next;
   logic [PERIOD_W-1:0] active_period_reg, active_period_next;
   logic [PERIOD_W-1:0] shadow_reg, shadow_next;
   logic                period_ready_reg, period_ready_next;
   logic                enc_a_reg, enc_a_next;
   logic                enc_b_reg, enc_b_next;
   logic                step_pulse_reg, step_pulse_next;
   logic [POS_W-1:0]    position_reg, position_next;

   logic                timer_load, timer_run, timer_zero;
   logic [PERIOD_W-1:0] timer_load_val;
   logic [PERIOD_W-1:0] clamped_period, effective_period;
   logic                accept;

   step_timer #(.PERIOD_W(PERIOD_W)) u_step_timer (
      .clock        (clock),
      .system_reset (system_reset),
      .load         (timer_load),
      .load_val     (timer_load_val),
      .run          (timer_run),
      .zero         (timer_zero)
   );

   // The shadow is full exactly when ready is low, so ready doubles as the empty flag.
   assign accept           = period_valid && period_ready_reg;
   assign clamped_period   = (period_in < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period_in;
   assign effective_period = period_ready_reg ? active_period_reg : shadow_reg;

   always_comb begin
      state_next         = state_reg;
      phase_next         = phase_reg;
      active_period_next = active_period_reg;
      shadow_next        = shadow_reg;
      period_ready_next  = period_ready_reg;
      enc_a_next         = enc_a_reg;
      enc_b_next         = enc_b_reg;
      step_pulse_next    = 1'b0;
      position_next      = position_reg;
      timer_load         = 1'b0;
      timer_load_val     = '0;
      timer_run          = 1'b0;

      if (accept) begin
         shadow_next       = clamped_period;
         period_ready_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (!period_ready_reg) begin
               active_period_next = shadow_reg;
               period_ready_next  = 1'b1;
            end
            if (enable) begin
               state_next     = RUN;
               timer_load     = 1'b1;
               timer_load_val = effective_period - PERIOD_W'(1);
            end
         end
         RUN: begin
            // Disable wins over a coincident step boundary.
            if (!enable) begin
               state_next = IDLE;
               timer_load = 1'b1;
            end else if (timer_zero) begin
               phase_next      = next_phase(phase_reg, dir);
               enc_a_next      = phase_a(phase_next);
               enc_b_next      = phase_b(phase_next);
               step_pulse_next = 1'b1;
               position_next   = position_reg + (dir ? POS_W'(1) : {POS_W{1'b1}});
               timer_load      = 1'b1;
               timer_load_val  = effective_period - PERIOD_W'(1);
               if (!period_ready_reg) begin
                  active_period_next = shadow_reg;
                  period_ready_next  = 1'b1;
               end
            end else begin
               timer_run = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge system_reset) begin
      if (!system_reset) begin
         state_reg         <= IDLE;
         phase_reg         <= P00;
         active_period_reg <= PERIOD_W'(RESET_PERIOD);
         shadow_reg        <= '0;
         period_ready_reg  <= 1'b1;
         enc_a_reg         <= 1'b0;
         enc_b_reg         <= 1'b0;
         step_pulse_reg    <= 1'b0;
         position_reg      <= '0;
      end else begin
         state_reg         <= state_next;
         phase_reg         <= phase_next;
         active_period_reg <= active_period_next;
         shadow_reg        <= shadow_next;
         period_ready_reg  <= period_ready_next;
         enc_a_reg         <= enc_a_next;
         enc_b_reg         <= enc_b_next;
         step_pulse_reg    <= step_pulse_next;
         position_reg      <= position_next;
      end
   end

   assign period_ready = period_ready_reg;
   assign enc_a        = enc_a_reg;
   assign enc_b        = enc_b_reg;
   assign encoder_data = enc_a_reg;
   assign step_pulse   = step_pulse_reg;
   assign position     = position_reg;

endmodule
